// File: rtl/dma_wdata_realigner.sv
// Realigns a byte-packed input stream to an arbitrary destination byte address as AXI-style write bursts.
// Latency: one cycle from input accept (or flush issue) to w_valid; aw_valid one cycle after run.
// Backpressure: w_ready low holds the output register and drops in_ready; aw waits for aw_ready.
module dma_wdata_realigner #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 8,
    parameter int MAX_BEATS  = 256,
    parameter int BOUNDARY_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                run,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   nbytes,
    output logic                busy,
    output logic                done,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic                aw_valid,
    output logic [ADDR_W-1:0]   aw_addr,
    output logic [LEN_W-1:0]    aw_len,
    input  logic                aw_ready,
    output logic                w_valid,
    output logic [DATA_W-1:0]   w_data,
    output logic [DATA_W/8-1:0] w_strb,
    output logic                w_last,
    input  logic                w_ready
);
    localparam int NB   = DATA_W / 8;
    localparam int OW   = $clog2(NB);
    localparam int SH_W = OW + 4;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;
    state_t state, state_nxt;

    logic [OW-1:0]     off, endl;
    logic [ADDR_W-1:0] addr, t_tot, i_tot, t_rem, k;
    logic [LEN_W:0]    blen, iss_cnt;
    logic [DATA_W-1:0] prev;
    logic              zero_done;

    logic [ADDR_W-1:0] t_calc, i_calc;
    logic [ADDR_W:0]   bnd_beats, burst_b;
    logic              cur_is_in, issue_ok, fire, last_hs;
    logic [DATA_W-1:0] cur, beat_dat;
    logic [2*DATA_W-1:0] cat;
    logic [SH_W-1:0]   sh;
    logic [OW:0]       rs;
    logic [NB-1:0]     ones, beat_strb;

    // Widened by one bit so the rounding add cannot wrap for large nbytes.
    assign t_calc = ADDR_W'(({1'b0, nbytes} + (ADDR_W+1)'(start_addr[OW-1:0])
                             + (ADDR_W+1)'(NB-1)) >> OW);
    assign i_calc = ADDR_W'(({1'b0, nbytes} + (ADDR_W+1)'(NB-1)) >> OW);

    always_comb begin
        bnd_beats = (((ADDR_W+1)'(1) << BOUNDARY_W) - (ADDR_W+1)'(addr[BOUNDARY_W-1:0])) >> OW;
        burst_b   = {1'b0, t_rem};
        if (bnd_beats < burst_b)
            burst_b = bnd_beats;
        if ((ADDR_W+1)'(MAX_BEATS) < burst_b)
            burst_b = (ADDR_W+1)'(MAX_BEATS);
    end

    // Beat k is built from input k (or zeros on the flush beat) and the previous input word.
    assign cur_is_in = (k < i_tot);
    assign cur       = cur_is_in ? in_data : '0;
    assign cat       = {cur, prev};
    assign sh        = (SH_W'(NB) - SH_W'(off)) << 3;
    assign beat_dat  = DATA_W'(cat >> sh);
    assign ones      = '1;
    assign rs        = (OW+1)'(NB) - (OW+1)'(endl);

    always_comb begin
        beat_strb = '1;
        if (k == '0)
            beat_strb = beat_strb & (ones << off);
        if (k == t_tot - ADDR_W'(1) && endl != '0)
            beat_strb = beat_strb & (ones >> rs);
    end

    assign issue_ok = (state == DATA) && (iss_cnt < blen) && (!w_valid || w_ready);
    assign in_ready = issue_ok && cur_is_in;
    assign fire     = issue_ok && (!cur_is_in || in_valid);
    assign last_hs  = w_valid && w_ready && w_last;

    assign aw_valid = (state == ADDR);
    assign aw_addr  = aw_valid ? addr : '0;
    assign aw_len   = aw_valid ? LEN_W'(burst_b - (ADDR_W+1)'(1)) : '0;
    assign busy     = (state == ADDR) || (state == DATA);
    assign done     = (state == FIN) || zero_done;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (run && nbytes != '0) state_nxt = ADDR;
            ADDR: if (aw_ready) state_nxt = DATA;
            DATA: if (last_hs) state_nxt = (t_rem == '0) ? FIN : ADDR;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            off       <= '0;
            endl      <= '0;
            addr      <= '0;
            t_tot     <= '0;
            i_tot     <= '0;
            t_rem     <= '0;
            k         <= '0;
            blen      <= '0;
            iss_cnt   <= '0;
            prev      <= '0;
            zero_done <= 1'b0;
            w_valid   <= 1'b0;
            w_data    <= '0;
            w_strb    <= '0;
            w_last    <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            off       <= '0;
            endl      <= '0;
            addr      <= '0;
            t_tot     <= '0;
            i_tot     <= '0;
            t_rem     <= '0;
            k         <= '0;
            blen      <= '0;
            iss_cnt   <= '0;
            prev      <= '0;
            zero_done <= 1'b0;
            w_valid   <= 1'b0;
            w_data    <= '0;
            w_strb    <= '0;
            w_last    <= 1'b0;
        end else begin
            state     <= state_nxt;
            zero_done <= 1'b0;
            if (state == IDLE && run) begin
                off       <= start_addr[OW-1:0];
                endl      <= OW'(start_addr[OW-1:0] + nbytes[OW-1:0]);
                addr      <= start_addr & ~ADDR_W'(NB-1);
                t_tot     <= t_calc;
                i_tot     <= i_calc;
                t_rem     <= t_calc;
                k         <= '0;
                prev      <= '0;
                zero_done <= (nbytes == '0);
            end
            if (state == ADDR && aw_ready) begin
                blen    <= (LEN_W+1)'(burst_b);
                iss_cnt <= '0;
                addr    <= addr + ADDR_W'(burst_b << OW);
                t_rem   <= t_rem - ADDR_W'(burst_b);
            end
            if (fire) begin
                w_valid <= 1'b1;
                w_data  <= beat_dat;
                w_strb  <= beat_strb;
                w_last  <= (iss_cnt == blen - (LEN_W+1)'(1));
                k       <= k + ADDR_W'(1);
                iss_cnt <= iss_cnt + (LEN_W+1)'(1);
                if (cur_is_in)
                    prev <= in_data;
            end else if (w_ready) begin
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dma_wdata_realigner.sv
// Directed bench for dma_wdata_realigner: aligned, unaligned, flush, 4KB split, MAX_BEATS split,
// stall, clear, reset and zero-length transfers against hand-computed beats.
module tb_dma_wdata_realigner;
    logic        clk = 1'b0;
    logic        rst, clear, run;
    logic [31:0] start_addr, nbytes;
    logic        busy, done;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic        w_valid, w_last, w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    dma_wdata_realigner dut (
        .clk(clk), .rst(rst), .clear(clear), .run(run),
        .start_addr(start_addr), .nbytes(nbytes), .busy(busy), .done(done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_len(aw_len), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_ready(w_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] in_words   [0:299];
    logic [31:0] exp_data   [0:299];
    logic [3:0]  exp_strb   [0:299];
    logic        exp_last   [0:299];
    logic [31:0] exp_aw_addr[0:3];
    logic [7:0]  exp_aw_len [0:3];
    int nin, nexp_w, nexp_aw, stall_at;
    bit xfer_end;

    task chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task set_w(input int i, input logic [31:0] d, input logic [3:0] s, input logic l);
        exp_data[i] = d;
        exp_strb[i] = s;
        exp_last[i] = l;
    endtask

    task set_aw(input int i, input logic [31:0] a, input logic [7:0] l);
        exp_aw_addr[i] = a;
        exp_aw_len[i]  = l;
    endtask

    task automatic xfer(input logic [31:0] a0, input logic [31:0] n);
        int in_hs, j, a, cyc, stall_cnt;
        bit seen_done;
        in_hs = 0; j = 0; a = 0; cyc = 0; stall_cnt = 0; seen_done = 0; xfer_end = 0;
        @(negedge clk);
        run = 1; start_addr = a0; nbytes = n;
        @(negedge clk);
        run = 0;
        chk("busy_start", busy, 1);
        fork
            begin
                while (!xfer_end) begin
                    in_valid = (in_hs < nin);
                    in_data  = (in_hs < nin) ? in_words[in_hs] : 32'h0;
                    #1;
                    if (in_valid && in_ready) in_hs++;
                    @(negedge clk);
                end
                in_valid = 0;
            end
            begin
                while (!seen_done && cyc < 2000) begin
                    aw_ready = 1;
                    w_ready  = !(j == stall_at && stall_cnt < 5);
                    #1;
                    if (aw_valid) begin
                        if (a < nexp_aw) begin
                            chk("aw_addr", aw_addr, exp_aw_addr[a]);
                            chk("aw_len", aw_len, exp_aw_len[a]);
                        end else
                            chk("aw_extra", a, nexp_aw);
                        a++;
                    end
                    if (w_valid && w_ready) begin
                        if (j < nexp_w) begin
                            chk("w_data", w_data, exp_data[j]);
                            chk("w_strb", w_strb, exp_strb[j]);
                            chk("w_last", w_last, exp_last[j]);
                        end else
                            chk("w_extra", j, nexp_w);
                        j++;
                    end
                    if (!w_ready) begin
                        chk("stall_w_valid", w_valid, 1);
                        chk("stall_w_data", w_data, exp_data[j]);
                        chk("stall_w_strb", w_strb, exp_strb[j]);
                        chk("stall_w_last", w_last, exp_last[j]);
                        chk("stall_in_ready", in_ready, 0);
                        stall_cnt++;
                    end
                    if (done) seen_done = 1;
                    else @(negedge clk);
                    cyc++;
                end
                aw_ready = 0;
                w_ready  = 0;
                xfer_end = 1;
            end
        join
        chk("done_seen", seen_done, 1);
        chk("in_handshakes", in_hs, nin);
        chk("w_beats", j, nexp_w);
        chk("aw_bursts", a, nexp_aw);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    initial begin
        rst = 1; clear = 0; run = 0; start_addr = 0; nbytes = 0;
        in_valid = 0; in_data = 0; aw_ready = 0; w_ready = 0; stall_at = -1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aw_valid", aw_valid, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        rst = 0;

        // aligned, two beats
        in_words[0] = 32'h03020100; in_words[1] = 32'h07060504; nin = 2;
        set_aw(0, 32'h1000, 8'd1); nexp_aw = 1;
        set_w(0, 32'h03020100, 4'hF, 0); set_w(1, 32'h07060504, 4'hF, 1); nexp_w = 2;
        xfer(32'h1000, 32'd5 + 32'd3);

        // offset 1, partial last strobe
        in_words[0] = 32'h44332211; in_words[1] = 32'h00000055; nin = 2;
        set_aw(0, 32'h1000, 8'd1); nexp_aw = 1;
        set_w(0, 32'h33221100, 4'hE, 0); set_w(1, 32'h00005544, 4'h3, 1); nexp_w = 2;
        xfer(32'h1001, 32'd5);

        // offset 3: one input word, flush beat
        in_words[0] = 32'hDDCCBBAA; nin = 1;
        set_aw(0, 32'h1000, 8'd1); nexp_aw = 1;
        set_w(0, 32'hAA000000, 4'h8, 0); set_w(1, 32'h00DDCCBB, 4'h7, 1); nexp_w = 2;
        xfer(32'h1003, 32'd4);

        // 4KB boundary split
        in_words[0] = 32'h13121110; in_words[1] = 32'h17161514;
        in_words[2] = 32'h1B1A1918; in_words[3] = 32'h1F1E1D1C; nin = 4;
        set_aw(0, 32'h0FF8, 8'd1); set_aw(1, 32'h1000, 8'd1); nexp_aw = 2;
        set_w(0, 32'h13121110, 4'hF, 0); set_w(1, 32'h17161514, 4'hF, 1);
        set_w(2, 32'h1B1A1918, 4'hF, 0); set_w(3, 32'h1F1E1D1C, 4'hF, 1); nexp_w = 4;
        xfer(32'h0FF8, 32'd16);

        // MAX_BEATS split: 257 beats
        for (int i = 0; i < 257; i++) begin
            in_words[i] = 32'hA5000000 | i;
            set_w(i, 32'hA5000000 | i, 4'hF, (i == 255) || (i == 256));
        end
        nin = 257; nexp_w = 257;
        set_aw(0, 32'h0, 8'd255); set_aw(1, 32'h400, 8'd0); nexp_aw = 2;
        xfer(32'h0, 32'd1028);

        // w_ready stalled for 5 cycles on beat 2
        for (int i = 0; i < 6; i++) begin
            in_words[i] = 32'h5A5A0000 + i;
            set_w(i, 32'h5A5A0000 + i, 4'hF, i == 5);
        end
        nin = 6; nexp_w = 6;
        set_aw(0, 32'h2000, 8'd5); nexp_aw = 1;
        stall_at = 2;
        xfer(32'h2000, 32'd24);
        stall_at = -1;

        // clear mid-burst
        @(negedge clk); run = 1; start_addr = 32'h3000; nbytes = 32'd32;
        @(negedge clk); run = 0; aw_ready = 1; w_ready = 0; in_valid = 1; in_data = 32'h12345678;
        @(negedge clk); @(negedge clk);
        chk("pre_clear_w_valid", w_valid, 1);
        clear = 1;
        @(negedge clk);
        chk("clear_w_valid", w_valid, 0);
        chk("clear_busy", busy, 0);
        chk("clear_done", done, 0);
        clear = 0; aw_ready = 0; in_valid = 0;

        // reset mid-burst
        @(negedge clk); run = 1; start_addr = 32'h3000; nbytes = 32'd32;
        @(negedge clk); run = 0; aw_ready = 1; w_ready = 1; in_valid = 1; in_data = 32'hCAFEF00D;
        @(negedge clk); @(negedge clk);
        chk("pre_rst_w_valid", w_valid, 1);
        #2 rst = 1;
        #1;
        chk("mid_rst_aw_valid", aw_valid, 0);
        chk("mid_rst_w_valid", w_valid, 0);
        chk("mid_rst_w_data", w_data, 0);
        chk("mid_rst_w_strb", w_strb, 0);
        chk("mid_rst_w_last", w_last, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        aw_ready = 0; w_ready = 0; in_valid = 0; in_data = 0;
        @(negedge clk); rst = 0;

        // zero-length transfer
        @(negedge clk); run = 1; start_addr = 32'h5000; nbytes = 32'd0;
        @(negedge clk); run = 0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_aw_valid", aw_valid, 0);
        @(negedge clk);
        chk("zero_done_drop", done, 0);
        chk("zero_busy_after", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
